branch_resolve_feedback: RTL and testbench
==========================================

Name: branch_resolve_feedback

Overview:
- Tracks every in-flight control-flow instruction (branch, JAL, JALR) by ROB tag, from dispatch to commit.
- Captures the fetch-time prediction at dispatch and the ALU resolution out of order.
- At in-order commit, drives the predictor update interface (enable, real outcome, index, target).
- On misprediction, drives the pipeline flush (jump_wrong) and the redirect PC to fetch.

Parameters:
- ROB_IDX_W, 4: ROB tag width; table depth is 2**ROB_IDX_W.
- ADDR_W, 32: PC width.
- PRED_IDX_W, 8: predictor table index width; index = pc[PRED_IDX_W+1:2].
- FLUSH_CYCLES, 2: number of cycles jump_wrong is held high (1..15).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; when low, all state and outputs hold
- disp_valid  in  1  control-flow instruction dispatched this cycle
- disp_tag  in  ROB_IDX_W  its ROB tag
- disp_pc  in  ADDR_W  instruction PC
- disp_pred_taken  in  1  fetch-time taken prediction
- disp_pred_pc  in  ADDR_W  fetch-time predicted target
- res_valid  in  1  ALU resolution broadcast
- res_tag  in  ROB_IDX_W  resolved tag
- res_taken  in  1  real outcome
- res_target  in  ADDR_W  real target when taken
- commit_valid  in  1  ROB head is a control-flow instruction that wants to commit
- commit_tag  in  ROB_IDX_W  ROB head tag
- commit_ready  out  1  head entry valid and resolved (combinational)
- fb_enable  out  1  one-cycle predictor update pulse
- fb_taken  out  1  real outcome
- fb_index  out  PRED_IDX_W  predictor index
- fb_target  out  ADDR_W  real target
- jump_wrong  out  1  flush request
- redirect_pc  out  ADDR_W  correct next PC, valid while jump_wrong is high

Behaviour:
- Table entry fields: valid, resolved, pc, pred_taken, pred_pc, act_taken, act_target.
- Reset: all valid/resolved cleared; fb_enable=0, fb_taken=0, fb_index=0, fb_target=0, jump_wrong=0, redirect_pc=0; FSM=RUN; flush counter=0.
- FSM RUN:
  - Dispatch writes entry[disp_tag] with valid=1, resolved=0.
  - Resolve applies only if entry[res_tag].valid (after any same-cycle dispatch write). It sets resolved=1, act_taken, act_target.
  - commit_ready = commit_valid && entry[commit_tag].valid && entry[commit_tag].resolved.
  - Commit accept is commit_ready sampled on the clock edge. On accept, entry.valid is cleared, and on the next cycle:
    - fb_enable=1 for exactly 1 cycle.
    - fb_taken=act_taken, fb_target=act_target, fb_index=pc[PRED_IDX_W+1:2].
- Mispredict = (pred_taken != act_taken) || (act_taken && pred_pc != act_target).
- On mispredict at commit:
  - The next cycle sets jump_wrong=1 and redirect_pc = act_taken ? act_target : pc+4 (mod 2**ADDR_W).
  - All valid bits are cleared and the FSM enters FLUSH.
- FSM FLUSH:
  - jump_wrong is held high for FLUSH_CYCLES cycles total; then jump_wrong=0 and the FSM returns to RUN.
  - dispatch, resolve and commit inputs are ignored; commit_ready=0; fb_enable=0 after its first pulse.
- Simultaneous events:
  - Commit and dispatch on the same tag: commit uses the old contents; the entry ends valid with the new dispatch data.
  - Resolve on the same tag as commit in the same cycle: commit is not ready that cycle, unless the optional feature below is enabled.
- Late events: a resolve to an invalid tag is dropped. A commit to an unresolved entry stalls (commit_ready=0) with no side effects.
- rst mid-FLUSH returns immediately to the reset state.
- Latency: commit accept to fb_enable/jump_wrong = 1 cycle.

Optional Feature:
- Macro: BRF_RESOLVE_BYPASS_EN.
- When defined: a res_valid whose res_tag equals commit_tag (entry valid) makes commit_ready=1 in the same cycle. Commit then uses res_taken/res_target, which saves one cycle per late branch.
- When undefined: commit waits for the stored resolved bit, giving 1 extra cycle.

Decomposition:
- Shared define file gets:
  - TRUE/FALSE.
  - Address width.
  - Predictor index slice macro.
  - FSM state encodings RUN=1'b0, FLUSH=1'b1.
- One natural sub-module, brf_entry_table: the storage array with write ports for dispatch and resolve, a read port for commit, and clear-all.
- Top level holds the compare logic, the FSM and the output registers.

Test Plan:
- Correct not-taken branch: dispatch tag3 pc=0x100 pred_taken=0; resolve tag3 taken=0; commit tag3. Required: fb_enable pulse, fb_taken=0, fb_index=0x40, jump_wrong=0.
- Mispredicted taken: dispatch tag5 pc=0x200 pred_taken=0; resolve taken=1 target=0x180; commit. Required: jump_wrong high 2 cycles, redirect_pc=0x180, fb_taken=1, fb_target=0x180, then commit_ready=0 for tag5 (entry cleared).
- Wrong target: JALR dispatched with pred_taken=1 pred_pc=0x0; resolve target=0x1234; commit. Required: jump_wrong=1, redirect_pc=0x1234.
- Out-of-order resolve: dispatch tags 1, 2; resolve tag2 then tag1; commit tag1 then tag2. Required: commit tag1 is not ready until its resolve arrives; two fb_enable pulses in program order.
- Flush/rdy/reset interplay:
  - Inputs during FLUSH are ignored.
  - rdy=0 for 3 cycles during RUN freezes fb/jump_wrong values.
  - rst asserted mid-FLUSH forces jump_wrong=0 next cycle.
- Same-cycle resolve+commit on tag7: commit_ready=1 with BRF_RESOLVE_BYPASS_EN defined, 0 without it.

Source files
------------

// File: rtl/branch_resolve_feedback_pkg.sv
// Shared types and constants for the branch resolve/feedback block.
package branch_resolve_feedback_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // Default PC width.
    localparam int unsigned ADDR_W_DEF = 32;

    // Predictor index is the word address: pc[PRED_IDX_W+1:PRED_IDX_LSB].
    localparam int unsigned PRED_IDX_LSB = 2;

    typedef enum logic {
        StRun   = 1'b0,
        StFlush = 1'b1
    } brf_state_e;

endpackage

// File: rtl/brf_entry_table.sv
// Per-ROB-tag storage for in-flight control-flow instructions.
// Write ports: dispatch (new entry), resolve (outcome), commit clear, clear-all.
// Read port: combinational lookup by commit tag.
module brf_entry_table
    import branch_resolve_feedback_pkg::*;
#(
    parameter int unsigned ROB_IDX_W = 4,
    parameter int unsigned ADDR_W    = ADDR_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_all,
    input  logic                 disp_we,
    input  logic [ROB_IDX_W-1:0] disp_tag,
    input  logic [ADDR_W-1:0]    disp_pc,
    input  logic                 disp_pred_taken,
    input  logic [ADDR_W-1:0]    disp_pred_pc,
    input  logic                 res_we,
    input  logic [ROB_IDX_W-1:0] res_tag,
    input  logic                 res_taken,
    input  logic [ADDR_W-1:0]    res_target,
    input  logic                 clr_we,
    input  logic [ROB_IDX_W-1:0] clr_tag,
    input  logic [ROB_IDX_W-1:0] rd_tag,
    output logic                 rd_valid,
    output logic                 rd_resolved,
    output logic [ADDR_W-1:0]    rd_pc,
    output logic                 rd_pred_taken,
    output logic [ADDR_W-1:0]    rd_pred_pc,
    output logic                 rd_act_taken,
    output logic [ADDR_W-1:0]    rd_act_target
);

    localparam int unsigned Depth = 1 << ROB_IDX_W;

    logic [Depth-1:0]  valid_q;
    logic [Depth-1:0]  resolved_q;
    logic [ADDR_W-1:0] pc_q         [Depth];
    logic              pred_taken_q [Depth];
    logic [ADDR_W-1:0] pred_pc_q    [Depth];
    logic              act_taken_q  [Depth];
    logic [ADDR_W-1:0] act_target_q [Depth];

    logic res_apply;

    // Resolve lands only on a live entry, counting a same-cycle dispatch to that tag.
    always_comb begin
        res_apply = res_we && (valid_q[res_tag] || (disp_we && (disp_tag == res_tag)));
    end

    // Valid/resolved flags; later assignments win (commit clear < dispatch < resolve).
    always_ff @(posedge clk) begin
        if (rst || clear_all) begin
            valid_q    <= '0;
            resolved_q <= '0;
        end else begin
            if (clr_we) begin
                valid_q[clr_tag] <= FALSE;
            end
            if (disp_we) begin
                valid_q[disp_tag]    <= TRUE;
                resolved_q[disp_tag] <= FALSE;
            end
            if (res_apply) begin
                resolved_q[res_tag] <= TRUE;
            end
        end
    end

    // Payload fields; meaningful only while the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (disp_we) begin
            pc_q[disp_tag]         <= disp_pc;
            pred_taken_q[disp_tag] <= disp_pred_taken;
            pred_pc_q[disp_tag]    <= disp_pred_pc;
        end
        if (res_apply) begin
            act_taken_q[res_tag]  <= res_taken;
            act_target_q[res_tag] <= res_target;
        end
    end

    // Commit read port returns pre-edge contents.
    always_comb begin
        rd_valid      = valid_q[rd_tag];
        rd_resolved   = resolved_q[rd_tag];
        rd_pc         = pc_q[rd_tag];
        rd_pred_taken = pred_taken_q[rd_tag];
        rd_pred_pc    = pred_pc_q[rd_tag];
        rd_act_taken  = act_taken_q[rd_tag];
        rd_act_target = act_target_q[rd_tag];
    end

endmodule

// File: rtl/branch_resolve_feedback.sv
// Tracks in-flight branches/JAL/JALR from dispatch to commit, drives the
// predictor update at commit and a flush plus redirect on misprediction.
// Optional: define BRF_RESOLVE_BYPASS_EN to let a same-cycle resolve of the
// head tag make it commit-ready immediately.
module branch_resolve_feedback
    import branch_resolve_feedback_pkg::*;
#(
    parameter int unsigned ROB_IDX_W    = 4,
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned PRED_IDX_W   = 8,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  disp_valid,
    input  logic [ROB_IDX_W-1:0]  disp_tag,
    input  logic [ADDR_W-1:0]     disp_pc,
    input  logic                  disp_pred_taken,
    input  logic [ADDR_W-1:0]     disp_pred_pc,
    input  logic                  res_valid,
    input  logic [ROB_IDX_W-1:0]  res_tag,
    input  logic                  res_taken,
    input  logic [ADDR_W-1:0]     res_target,
    input  logic                  commit_valid,
    input  logic [ROB_IDX_W-1:0]  commit_tag,
    output logic                  commit_ready,
    output logic                  fb_enable,
    output logic                  fb_taken,
    output logic [PRED_IDX_W-1:0] fb_index,
    output logic [ADDR_W-1:0]     fb_target,
    output logic                  jump_wrong,
    output logic [ADDR_W-1:0]     redirect_pc
);

    localparam logic [3:0] FlushLast = 4'(FLUSH_CYCLES - 1);

    brf_state_e state_q;
    logic [3:0] flush_cnt_q;

    logic              run;
    logic              disp_we;
    logic              res_we;
    logic              commit_accept;
    logic              clear_all;
    logic              bypass_hit;
    logic              rd_valid;
    logic              rd_resolved;
    logic [ADDR_W-1:0] rd_pc;
    logic              rd_pred_taken;
    logic [ADDR_W-1:0] rd_pred_pc;
    logic              rd_act_taken;
    logic [ADDR_W-1:0] rd_act_target;
    logic              eff_taken;
    logic [ADDR_W-1:0] eff_target;
    logic              mispredict;

    // Input qualification: nothing is accepted while frozen or flushing.
    always_comb begin
        run     = (state_q == StRun);
        disp_we = rdy && run && disp_valid;
        res_we  = rdy && run && res_valid;
    end

`ifdef BRF_RESOLVE_BYPASS_EN
    // Forward a same-cycle resolve of the head tag straight into commit.
    always_comb begin
        bypass_hit = res_valid && (res_tag == commit_tag);
    end
`else
    // Commit waits for the stored resolved bit.
    always_comb begin
        bypass_hit = FALSE;
    end
`endif

    // Commit readiness, effective outcome and mispredict compare.
    always_comb begin
        eff_taken     = bypass_hit ? res_taken : rd_act_taken;
        eff_target    = bypass_hit ? res_target : rd_act_target;
        commit_ready  = rdy && run && commit_valid && rd_valid && (rd_resolved || bypass_hit);
        commit_accept = commit_ready;
        mispredict    = (rd_pred_taken != eff_taken) ||
                        (eff_taken && (rd_pred_pc != eff_target));
        clear_all     = commit_accept && mispredict;
    end

    brf_entry_table #(
        .ROB_IDX_W (ROB_IDX_W),
        .ADDR_W    (ADDR_W)
    ) u_table (
        .clk             (clk),
        .rst             (rst),
        .clear_all       (clear_all),
        .disp_we         (disp_we),
        .disp_tag        (disp_tag),
        .disp_pc         (disp_pc),
        .disp_pred_taken (disp_pred_taken),
        .disp_pred_pc    (disp_pred_pc),
        .res_we          (res_we),
        .res_tag         (res_tag),
        .res_taken       (res_taken),
        .res_target      (res_target),
        .clr_we          (commit_accept),
        .clr_tag         (commit_tag),
        .rd_tag          (commit_tag),
        .rd_valid        (rd_valid),
        .rd_resolved     (rd_resolved),
        .rd_pc           (rd_pc),
        .rd_pred_taken   (rd_pred_taken),
        .rd_pred_pc      (rd_pred_pc),
        .rd_act_taken    (rd_act_taken),
        .rd_act_target   (rd_act_target)
    );

    // RUN/FLUSH FSM with registered feedback and flush outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            flush_cnt_q <= '0;
            fb_enable   <= FALSE;
            fb_taken    <= FALSE;
            fb_index    <= '0;
            fb_target   <= '0;
            jump_wrong  <= FALSE;
            redirect_pc <= '0;
        end else if (rdy) begin
            fb_enable <= FALSE;
            case (state_q)
                StRun: begin
                    if (commit_accept) begin
                        fb_enable <= TRUE;
                        fb_taken  <= eff_taken;
                        fb_target <= eff_target;
                        fb_index  <= rd_pc[PRED_IDX_W+PRED_IDX_LSB-1:PRED_IDX_LSB];
                        if (mispredict) begin
                            jump_wrong  <= TRUE;
                            redirect_pc <= eff_taken ? eff_target : rd_pc + ADDR_W'(4);
                            state_q     <= StFlush;
                            flush_cnt_q <= FlushLast;
                        end
                    end
                end
                StFlush: begin
                    // First flush cycle was the transition itself.
                    if (flush_cnt_q == '0) begin
                        jump_wrong <= FALSE;
                        state_q    <= StRun;
                    end else begin
                        flush_cnt_q <= flush_cnt_q - 4'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_resolve_feedback.sv
// Scoreboard bench for branch_resolve_feedback.
module tb_branch_resolve_feedback;

    localparam int unsigned ROB_IDX_W  = 4;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned PRED_IDX_W = 8;

`ifdef BRF_RESOLVE_BYPASS_EN
    localparam logic BypassEn = 1'b1;
`else
    localparam logic BypassEn = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  rdy;
    logic                  disp_valid;
    logic [ROB_IDX_W-1:0]  disp_tag;
    logic [ADDR_W-1:0]     disp_pc;
    logic                  disp_pred_taken;
    logic [ADDR_W-1:0]     disp_pred_pc;
    logic                  res_valid;
    logic [ROB_IDX_W-1:0]  res_tag;
    logic                  res_taken;
    logic [ADDR_W-1:0]     res_target;
    logic                  commit_valid;
    logic [ROB_IDX_W-1:0]  commit_tag;
    logic                  commit_ready;
    logic                  fb_enable;
    logic                  fb_taken;
    logic [PRED_IDX_W-1:0] fb_index;
    logic [ADDR_W-1:0]     fb_target;
    logic                  jump_wrong;
    logic [ADDR_W-1:0]     redirect_pc;

    branch_resolve_feedback u_dut (
        .clk             (clk),
        .rst             (rst),
        .rdy             (rdy),
        .disp_valid      (disp_valid),
        .disp_tag        (disp_tag),
        .disp_pc         (disp_pc),
        .disp_pred_taken (disp_pred_taken),
        .disp_pred_pc    (disp_pred_pc),
        .res_valid       (res_valid),
        .res_tag         (res_tag),
        .res_taken       (res_taken),
        .res_target      (res_target),
        .commit_valid    (commit_valid),
        .commit_tag      (commit_tag),
        .commit_ready    (commit_ready),
        .fb_enable       (fb_enable),
        .fb_taken        (fb_taken),
        .fb_index        (fb_index),
        .fb_target       (fb_target),
        .jump_wrong      (jump_wrong),
        .redirect_pc     (redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        taken;
        logic [31:0] index;
        logic [31:0] target;
        logic        mis;
        logic [31:0] redirect;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model of each tag's dispatch and resolve data.
    logic [31:0] m_pc   [16];
    logic        m_pt   [16];
    logic [31:0] m_ppc  [16];
    logic        m_at   [16];
    logic [31:0] m_atgt [16];

    logic rdy_e = 1'b0;
    logic rst_e = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic dispatch(input int tag, input logic [31:0] pc, input logic pt,
                            input logic [31:0] ppc);
        disp_valid = 1'b1; disp_tag = 4'(tag); disp_pc = pc;
        disp_pred_taken = pt; disp_pred_pc = ppc;
        m_pc[tag] = pc; m_pt[tag] = pt; m_ppc[tag] = ppc;
        cycle();
        disp_valid = 1'b0;
    endtask

    task automatic resolve(input int tag, input logic t, input logic [31:0] tgt);
        res_valid = 1'b1; res_tag = 4'(tag); res_taken = t; res_target = tgt;
        m_at[tag] = t; m_atgt[tag] = tgt;
        cycle();
        res_valid = 1'b0;
    endtask

    task automatic push_exp(input int tag);
        exp_t e;
        e.taken    = m_at[tag];
        e.target   = m_atgt[tag];
        e.index    = {24'h0, m_pc[tag][9:2]};
        e.mis      = (m_pt[tag] != m_at[tag]) || (m_at[tag] && (m_ppc[tag] != m_atgt[tag]));
        e.redirect = m_at[tag] ? m_atgt[tag] : m_pc[tag] + 32'd4;
        sb_q.push_back(e);
    endtask

    // Holds commit_valid until the DUT accepts, bounded.
    task automatic commit(input int tag);
        bit done = 1'b0;
        commit_valid = 1'b1; commit_tag = 4'(tag);
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            if (commit_ready) begin
                push_exp(tag);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        commit_valid = 1'b0;
        if (!done) check("commit_timeout", 32'd0, 32'd1);
    endtask

    always @(posedge clk) begin
        rdy_e <= rdy;
        rst_e <= rst;
    end

    // A pulse is fresh only if the last edge actually updated state.
    always @(negedge clk) begin
        if (fb_enable && rdy_e && !rst_e) begin
            if (sb_q.size() == 0) begin
                check("fb_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("fb_taken", {31'h0, fb_taken}, {31'h0, e.taken});
                check("fb_index", {24'h0, fb_index}, e.index);
                check("fb_target", fb_target, e.target);
                check("jump_wrong", {31'h0, jump_wrong}, {31'h0, e.mis});
                if (e.mis) check("redirect_pc", redirect_pc, e.redirect);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst = 1'b1; rdy = 1'b1;
        disp_valid = 1'b0; disp_tag = '0; disp_pc = '0; disp_pred_taken = 1'b0;
        disp_pred_pc = '0; res_valid = 1'b0; res_tag = '0; res_taken = 1'b0;
        res_target = '0; commit_valid = 1'b0; commit_tag = '0;
        repeat (3) cycle();
        rst = 1'b0;

        // Reset state
        check("rst_fb_enable", {31'h0, fb_enable}, 32'd0);
        check("rst_fb_taken", {31'h0, fb_taken}, 32'd0);
        check("rst_fb_index", {24'h0, fb_index}, 32'd0);
        check("rst_fb_target", fb_target, 32'd0);
        check("rst_jump_wrong", {31'h0, jump_wrong}, 32'd0);
        check("rst_redirect", redirect_pc, 32'd0);
        commit_valid = 1'b1; commit_tag = 4'd0; #1;
        check("rst_commit_ready", {31'h0, commit_ready}, 32'd0);
        commit_valid = 1'b0;
        cycle();

        // Correct not-taken branch
        dispatch(3, 32'h100, 1'b0, 32'h0);
        resolve(3, 1'b0, 32'h0);
        commit(3);
        cycle();

        // Mispredicted taken: flush length and entry cleared
        dispatch(5, 32'h200, 1'b0, 32'h0);
        resolve(5, 1'b1, 32'h180);
        commit(5);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (jump_wrong) cnt++;
            else break;
        end
        check("flush_len", 32'(cnt), 32'd2);
        cycle();
        commit_valid = 1'b1; commit_tag = 4'd5; #1;
        check("tag5_cleared", {31'h0, commit_ready}, 32'd0);
        commit_valid = 1'b0;
        cycle();

        // Wrong JALR target; inputs during FLUSH are ignored
        dispatch(6, 32'h300, 1'b1, 32'h0);
        resolve(6, 1'b1, 32'h1234);
        commit(6);
        check("jalr_jw", {31'h0, jump_wrong}, 32'd1);
        dispatch(8, 32'h340, 1'b0, 32'h0);
        resolve(8, 1'b0, 32'h0);
        check("flush_done", {31'h0, jump_wrong}, 32'd0);
        commit_valid = 1'b1; commit_tag = 4'd8; #1;
        check("flush_ignored", {31'h0, commit_ready}, 32'd0);
        commit_valid = 1'b0;
        cycle();

        // Out-of-order resolve, in-order commit
        dispatch(1, 32'h400, 1'b0, 32'h0);
        dispatch(2, 32'h404, 1'b1, 32'h500);
        resolve(2, 1'b1, 32'h500);
        commit_valid = 1'b1; commit_tag = 4'd1; #1;
        check("tag1_not_ready", {31'h0, commit_ready}, 32'd0);
        commit_valid = 1'b0;
        resolve(1, 1'b0, 32'h0);
        commit(1);
        commit(2);

        // rdy low freezes the feedback pulse
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("frz_fb_enable", {31'h0, fb_enable}, 32'd1);
            check("frz_fb_index", {24'h0, fb_index}, 32'd1);
            check("frz_jw", {31'h0, jump_wrong}, 32'd0);
        end
        rdy = 1'b1;
        cycle();
        check("unfrz_fb_enable", {31'h0, fb_enable}, 32'd0);

        // Reset mid-FLUSH
        dispatch(9, 32'h600, 1'b1, 32'h700);
        resolve(9, 1'b0, 32'h0);
        commit(9);
        rst = 1'b1;
        cycle();
        check("rst_flush_jw", {31'h0, jump_wrong}, 32'd0);
        check("rst_flush_redirect", redirect_pc, 32'd0);
        rst = 1'b0;
        cycle();

        // Same-cycle resolve and commit on tag 7
        dispatch(7, 32'h700, 1'b0, 32'h0);
        res_valid = 1'b1; res_tag = 4'd7; res_taken = 1'b0; res_target = 32'h0;
        m_at[7] = 1'b0; m_atgt[7] = 32'h0;
        commit_valid = 1'b1; commit_tag = 4'd7; #1;
        check("same_cycle_ready", {31'h0, commit_ready}, {31'h0, BypassEn});
        if (commit_ready) push_exp(7);
        cycle();
        res_valid = 1'b0; commit_valid = 1'b0;
        if (!BypassEn) commit(7);

        repeat (4) cycle();
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
